// File: rtl/adc_capture_disp_pkg.sv
// Shared constants for the ADC capture/display slice: 7-segment patterns and
// a counter-width helper.
package adc_capture_disp_pkg;

    // Segment order {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Bits needed to hold 0..n-1, never less than 1
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'd1 << w) < 64'(n))) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder with a dash override.
module seg7_hex_decode
    import adc_capture_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dash,
    output logic [6:0] pattern_c
);

    always_comb begin
        pattern_c = SEG_BLANK;
        if (dash) begin
            pattern_c = SEG_DASH;
        end else begin
            case (nibble)
                4'h0: pattern_c = SEG_0;
                4'h1: pattern_c = SEG_1;
                4'h2: pattern_c = SEG_2;
                4'h3: pattern_c = SEG_3;
                4'h4: pattern_c = SEG_4;
                4'h5: pattern_c = SEG_5;
                4'h6: pattern_c = SEG_6;
                4'h7: pattern_c = SEG_7;
                4'h8: pattern_c = SEG_8;
                4'h9: pattern_c = SEG_9;
                4'hA: pattern_c = SEG_A;
                4'hB: pattern_c = SEG_B;
                4'hC: pattern_c = SEG_C;
                4'hD: pattern_c = SEG_D;
                4'hE: pattern_c = SEG_E;
                4'hF: pattern_c = SEG_F;
                default: pattern_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_disp.sv
// ADC clock generation, decimating averager with sticky over-range, and a
// multiplexed hex 7-segment display of the latest average.
module adc_capture_disp
    import adc_capture_disp_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 2500
) (
    input  logic              clk,
    input  logic              nCR,
    input  logic [DATA_W-1:0] code,
    input  logic              hold,
    input  logic              ovr_clr,
    output logic              adc_clk,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    output logic              ovr,
    output logic [2:0]        seg_sel,
    output logic [6:0]        seg
);

    localparam int unsigned DIV_W  = clog2(CLK_DIV);
    localparam int unsigned SMP_W  = clog2(SAMPLE_DIV);
    localparam int unsigned SCN_W  = clog2(SCAN_DIV);
    localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
    localparam int unsigned AVG_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned DISP_W = 4 * DIGITS;

    logic [DIV_W-1:0]  div_cnt;
    logic [SMP_W-1:0]  samp_cnt;
    logic [SCN_W-1:0]  scan_cnt;
    logic [ACC_W-1:0]  acc;
    logic [AVG_W-1:0]  avg_cnt;
    logic [DATA_W-1:0] disp_q;
    logic [2:0]        dig;

    logic              div_tc_c;
    logic              fall_c;
    logic              strobe_c;
    logic              avg_last_c;
    logic              extreme_c;
    logic              scan_tc_c;
    logic [ACC_W-1:0]  sum_c;
    logic [3:0]        nib_c;
    logic [6:0]        pat_c;

    always_comb begin
        div_tc_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
        fall_c     = div_tc_c && adc_clk;
        strobe_c   = fall_c && (samp_cnt == SMP_W'(SAMPLE_DIV - 1));
        avg_last_c = (avg_cnt == AVG_W'((2 ** AVG_LOG2) - 1));
        sum_c      = acc + ACC_W'(code);
        extreme_c  = (code == '1) || (code == '0);
        scan_tc_c  = (scan_cnt == SCN_W'(SCAN_DIV - 1));
        nib_c      = 4'(DISP_W'(disp_q) >> {dig, 2'b00});
    end

    // ADC clock divider; the sample strobe fires on a falling adc_clk event
    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            div_cnt  <= '0;
            adc_clk  <= 1'b0;
            samp_cnt <= '0;
        end else begin
            if (div_tc_c) begin
                div_cnt <= '0;
                adc_clk <= ~adc_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_c) begin
                samp_cnt <= strobe_c ? '0 : samp_cnt + SMP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            acc       <= '0;
            avg_cnt   <= '0;
            avg_data  <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (strobe_c) begin
                if (avg_last_c) begin
                    acc       <= '0;
                    avg_cnt   <= '0;
                    avg_data  <= DATA_W'(sum_c >> AVG_LOG2);
                    avg_valid <= 1'b1;
                end else begin
                    acc     <= sum_c;
                    avg_cnt <= avg_cnt + AVG_W'(1);
                end
            end
        end
    end

    // Sticky over-range (a new set beats a simultaneous clear) and held display value
    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            ovr    <= 1'b0;
            disp_q <= '0;
        end else begin
            if (strobe_c && extreme_c) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
            if (avg_valid && !hold) begin
                disp_q <= avg_data;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble    (nib_c),
        .dash      (ovr),
        .pattern_c (pat_c)
    );

    // Digit scanner: seg_sel and seg load together so they never disagree
    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            scan_cnt <= '0;
            dig      <= '0;
            seg_sel  <= '0;
            seg      <= SEG_BLANK;
        end else begin
            if (scan_tc_c) begin
                scan_cnt <= '0;
                seg_sel  <= dig;
                seg      <= pat_c;
                dig      <= (dig == 3'(DIGITS - 1)) ? '0 : dig + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCN_W'(1);
            end
        end
    end

endmodule
